cp0_timer_ctrl: RTL
===================

// Module: cp0_timer_ctrl
// PURPOSE
// Parametrised coprocessor-0 for the 5-stage MIPS pipeline. Sits beside the M stage.
// Holds SR, Cause, EPC, PRId, Count, Compare and BadVAddr.
// Arbitrates exceptions against hardware, software and timer interrupts.
// Drives the take/EPC pair that redirects NPC to the handler or back via ERET.
// PARAMETERS
// NUM_HWINT   6             external interrupt lines, 1..6, mapped to Cause.IP[10+:NUM_HWINT]
// TIMER_LINE  5             IP index (0..5, relative to bit 10) the timer interrupt is ORed onto
// TIMER_DIV   1             Count increments once every TIMER_DIV cycles (>=1)
// PRID_VAL    32'h12345678  reset/constant value of PRId (read-only)
// PORTS
// clk        in   1          clock, all state updates on posedge
// reset      in   1          synchronous, active-low reset
// hw_int     in   NUM_HWINT  external interrupt levels
// exc_valid  in   1          M-stage instruction raises an exception this cycle
// exc_code   in   5          ExcCode of that exception (AdEL=4, AdES=5, RI=10, Ov=12)
// is_bd      in   1          M-stage instruction sits in a branch delay slot
// pc_m       in   32         PC of M-stage instruction
// bad_addr   in   32         faulting address for AdEL/AdES
// eret       in   1          ERET in M stage
// we         in   1          MTC0 write enable
// waddr      in   5          MTC0 register number
// wdata      in   32         MTC0 data
// raddr      in   5          MFC0 register number
// rdata      out  32         MFC0 data, combinational
// take       out  1          exception/interrupt accepted this cycle; flush pipeline, PC<=handler
// epc_o      out  32         current EPC register (ERET target)
// exl_o      out  1          SR.EXL
// BEHAVIOUR
// - Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId.
// - Unmapped raddr reads 0; writes to unmapped or read-only regs (8, 15) are dropped.
// - SR = {16'b0, IM[15:8], 6'b0, EXL, IE}.
// - Cause = {BD, TI, 14'b0, IP[15:8], 1'b0, ExcCode[6:2], 2'b0}.
// - Reset (reset==0 at posedge):
//     SR=0, Cause=0, EPC=0, BadVAddr=0, Count=0, prescaler=0, Compare=32'hFFFF_FFFF.
//     Outputs after reset: take=0 (if exc_valid=0), epc_o=0, exl_o=0.
//     Reset mid-operation overrides every other event that cycle.
// - IP[15:10]: registered each cycle from hw_int (unused lines read 0).
//   IP[10+TIMER_LINE] additionally ORs TI. IP[9:8] are software bits, writable only via MTC0 Cause.
// - int_req = |(live_pend & IM) & IE & !EXL.
//   live_pend uses hw_int and TI directly (not the registered copy), so the request is same-cycle.
// - take = exc_valid | int_req, combinational. No added latency: the handler fetch follows next cycle.
// - On take at posedge:
//     ExcCode <= exc_valid ? exc_code : 0 (Int). Exception beats interrupt.
//     EXL <= 1.
//     If EXL was 0: EPC <= is_bd ? {pc_m[31:2],2'b0}-4 : {pc_m[31:2],2'b0}, and BD <= is_bd.
//     If EXL was already 1 (nested exception): EPC and BD hold.
//     If exc_code is 4 or 5: BadVAddr <= bad_addr.
// - eret without take: EXL <= 0, BD <= 0. take and eret together: take wins, eret ignored.
// - MTC0 (we=1) is ignored in any cycle where take=1.
//     SR write loads IM and EXL/IE.
//     Cause write loads only IP[9:8].
//     EPC write loads full word.
//     Compare write loads and clears TI.
//     Count write loads and zeroes prescaler.
// - Timer:
//     prescaler counts 0..TIMER_DIV-1; tick when it equals TIMER_DIV-1, then wraps to 0.
//     On tick, Count <= Count+1, wrapping 32'hFFFF_FFFF -> 0.
//     TI sets (sticky) when a tick makes Count+1 == Compare; it is cleared only by a Compare write.
//     Compare write and match in the same cycle: the write wins, TI=0.
// - No read bypass: rdata reflects state before the same-cycle write.
// TESTING
// - Reset: hold reset=0 two cycles -> rdata(12)=0, rdata(11)=FFFF_FFFF, epc_o=0, take=0.
// - Interrupt: SR=0000_0401, hw_int[0]=1, pc_m=0000_3008, is_bd=0
//     -> take=1 same cycle; then EPC=3008, Cause.ExcCode=0, EXL=1, take=0 while EXL.
// - Delay slot: exc_valid=1, exc_code=12, is_bd=1, pc_m=0000_3010
//     -> EPC=300C, Cause=8000_0030; eret next cycle -> EXL=0, BD=0.
// - Timer (TIMER_DIV=4): Count=0, Compare=3, SR=IM[15]|IE
//     -> TI and take exactly 12 cycles after the Compare write; writing Compare=10 clears TI.
// - Conflicts:
//     take+eret same cycle -> EXL stays 1.
//     AdES with EXL=1, bad_addr=0000_0007 -> BadVAddr=7, EPC unchanged.
//     take+MTC0 EPC -> write dropped.
// - Software int: SR=0000_0101, MTC0 Cause=0000_0100 -> take next cycle, ExcCode=0.

Source files
------------

// File: rtl/cp0_timer_ctrl.sv
// rtl/cp0_timer_ctrl.sv - MIPS coprocessor-0: status/cause/EPC, exception and interrupt arbitration, Count/Compare timer
module cp0_timer_ctrl #(
    parameter int          NUM_HWINT  = 6,
    parameter int          TIMER_LINE = 5,
    parameter int          TIMER_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h1234_5678
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic                 is_bd,
    input  logic [31:0]          pc_m,
    input  logic [31:0]          bad_addr,
    input  logic                 eret,
    input  logic                 we,
    input  logic [4:0]           waddr,
    input  logic [31:0]          wdata,
    input  logic [4:0]           raddr,
    output logic [31:0]          rdata,
    output logic                 take,
    output logic [31:0]          epc_o,
    output logic                 exl_o
);

    localparam int              PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TIMER_DIV - 1);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    logic [7:0]    im_q, im_d;
    logic          ie_q, ie_d;
    logic          exl_q, exl_d;
    logic          bd_q, bd_d;
    logic          ti_q, ti_d;
    logic [5:0]    ip_hw_q, ip_hw_d;
    logic [1:0]    ip_sw_q, ip_sw_d;
    logic [4:0]    exccode_q, exccode_d;
    logic [31:0]   epc_q, epc_d;
    logic [31:0]   bva_q, bva_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [PW-1:0] presc_q, presc_d;

    logic [5:0]    hw_ext;
    logic [5:0]    ti_vec;
    logic [5:0]    ip_hw_view;
    logic [7:0]    live_pend;
    logic          int_req;
    logic          mtc0;
    logic          count_wr;
    logic          tick;
    logic [31:0]   count_inc;
    logic [31:0]   pc_aligned;
    logic [31:0]   epc_new;

    assign hw_ext     = 6'(hw_int);
    assign ti_vec     = ti_q ? (6'd1 << TIMER_LINE) : 6'd0;
    assign ip_hw_view = ip_hw_q | ti_vec;

    // Pending uses live hw_int so an interrupt is accepted in the cycle it arrives.
    assign live_pend = {hw_ext | ti_vec, ip_sw_q};
    assign int_req   = (|(live_pend & im_q)) & ie_q & ~exl_q;
    assign take      = exc_valid | int_req;

    assign mtc0       = we & ~take;
    assign count_wr   = mtc0 && (waddr == REG_COUNT);
    assign tick       = (presc_q == PRESC_MAX);
    assign count_inc  = count_q + 32'd1;
    assign pc_aligned = pc_m & ~32'd3;
    assign epc_new    = is_bd ? (pc_aligned - 32'd4) : pc_aligned;

    assign epc_o = epc_q;
    assign exl_o = exl_q;

    always_comb begin
        rdata = 32'd0;
        case (raddr)
            REG_BADVADDR: rdata = bva_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_q;
            REG_SR:       rdata = {16'd0, im_q, 6'd0, exl_q, ie_q};
            REG_CAUSE:    rdata = {bd_q, ti_q, 14'd0, ip_hw_view, ip_sw_q, 1'b0, exccode_q, 2'b00};
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = PRID_VAL;
            default:      rdata = 32'd0;
        endcase
    end

    always_comb begin
        im_d      = im_q;
        ie_d      = ie_q;
        exl_d     = exl_q;
        bd_d      = bd_q;
        ti_d      = ti_q;
        ip_hw_d   = hw_ext;
        ip_sw_d   = ip_sw_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        bva_d     = bva_q;
        count_d   = count_q;
        compare_d = compare_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;

        if (tick) begin
            count_d = count_inc;
            if (!count_wr && (count_inc == compare_q)) begin
                ti_d = 1'b1;
            end
        end

        if (take) begin
            exccode_d = exc_valid ? exc_code : 5'd0;
            exl_d     = 1'b1;
            // A nested exception keeps the outer return point.
            if (!exl_q) begin
                epc_d = epc_new;
                bd_d  = is_bd;
            end
            if (exc_valid && (exc_code == 5'd4 || exc_code == 5'd5)) begin
                bva_d = bad_addr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
            bd_d  = 1'b0;
        end

        if (mtc0) begin
            case (waddr)
                REG_COUNT: begin
                    count_d = wdata;
                    presc_d = '0;
                end
                REG_COMPARE: begin
                    compare_d = wdata;
                    ti_d      = 1'b0;
                end
                REG_SR: begin
                    im_d  = wdata[15:8];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                REG_CAUSE: ip_sw_d = wdata[9:8];
                REG_EPC:   epc_d   = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q      <= 8'd0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            ip_hw_q   <= 6'd0;
            ip_sw_q   <= 2'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
            bva_q     <= 32'd0;
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            presc_q   <= '0;
        end else begin
            im_q      <= im_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            ip_hw_q   <= ip_hw_d;
            ip_sw_q   <= ip_sw_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            bva_q     <= bva_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            presc_q   <= presc_d;
        end
    end

endmodule
